// File: rtl/kf8237_address_count_bank_pkg.sv
// Shared helpers for the KF8237 blocks: a lowest-bit-wins priority encoder
// and a byte-count helper for register widths.
package KF8237_Common_Package;

    localparam int MAX_CHANNELS = 8;

    // Narrower vectors are zero-extended by the caller; returns 0 when empty.
    function automatic int unsigned onehot2num(input logic [MAX_CHANNELS-1:0] onehot);
        int unsigned index;
        index = 0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                index = i;
            end
        end
        return index;
    endfunction

    function automatic int bytes_of(input int width);
        return (width < 8) ? 1 : width / 8;
    endfunction

endpackage

// File: rtl/kf8237_channel_registers.sv
// One DMA channel: base/current address and count, byte-wise CPU writes,
// initialize, step and auto-initialize reload with a terminal-count pulse.
module kf8237_channel_registers
    import KF8237_Common_Package::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int PTR_WIDTH   = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   master_clear,
    input  logic [7:0]             internal_data_bus,
    input  logic [PTR_WIDTH-1:0]   byte_pointer,
    input  logic                   write_address,
    input  logic                   write_count,
    input  logic                   initialize_current,
    input  logic                   step,
    input  logic                   address_hold,
    input  logic                   decrement_address,
    input  logic                   auto_initialize,
    output logic [ADDR_WIDTH-1:0]  current_address,
    output logic [COUNT_WIDTH-1:0] current_count,
    output logic                   next_high_bit,
    output logic                   tc_set
);

    localparam int ADDR_BYTES  = bytes_of(ADDR_WIDTH);
    localparam int COUNT_BYTES = bytes_of(COUNT_WIDTH);

    logic [ADDR_WIDTH-1:0]  base_address;
    logic [COUNT_WIDTH-1:0] base_count;
    logic [ADDR_WIDTH-1:0]  base_address_w;
    logic [ADDR_WIDTH-1:0]  current_address_w;
    logic [COUNT_WIDTH-1:0] base_count_w;
    logic [COUNT_WIDTH-1:0] current_count_w;
    logic [ADDR_WIDTH-1:0]  address_stepped;
    logic                   count_zero;
    logic                   cpu_write;

    // Byte-merge of the pointer-indexed byte into base and current copies.
    always_comb begin
        base_address_w    = base_address;
        current_address_w = current_address;
        base_count_w      = base_count;
        current_count_w   = current_count;
        for (int i = 0; i < ADDR_BYTES; i++) begin
            if (int'(byte_pointer) == i) begin
                base_address_w[i*8 +: 8]    = internal_data_bus;
                current_address_w[i*8 +: 8] = internal_data_bus;
            end
        end
        for (int i = 0; i < COUNT_BYTES; i++) begin
            if (int'(byte_pointer) == i) begin
                base_count_w[i*8 +: 8]    = internal_data_bus;
                current_count_w[i*8 +: 8] = internal_data_bus;
            end
        end
    end

    assign address_stepped = address_hold      ? current_address :
                             decrement_address ? current_address - ADDR_WIDTH'(1) :
                                                 current_address + ADDR_WIDTH'(1);
    assign count_zero = (current_count == '0);
    assign cpu_write  = write_address | write_count;

    // A step overridden by a CPU write or initialize is lost, TC included.
    assign tc_set = step & ~cpu_write & ~initialize_current & count_zero;

    if (ADDR_WIDTH > 8) begin : g_high
        assign next_high_bit = address_stepped[8];
    end else begin : g_no_high
        assign next_high_bit = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_address    <= '0;
            current_address <= '0;
            base_count      <= '0;
            current_count   <= '0;
        end else if (master_clear) begin
            base_address    <= '0;
            current_address <= '0;
            base_count      <= '0;
            current_count   <= '0;
        end else if (cpu_write) begin
            if (write_address) begin
                base_address    <= base_address_w;
                current_address <= current_address_w;
            end
            if (write_count) begin
                base_count    <= base_count_w;
                current_count <= current_count_w;
            end
        end else if (initialize_current) begin
            current_address <= base_address;
            current_count   <= base_count;
        end else if (step) begin
            if (count_zero && auto_initialize) begin
                current_address <= base_address;
                current_count   <= base_count;
            end else begin
                current_address <= address_stepped;
                current_count   <= current_count - COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/kf8237_address_count_bank.sv
// Address/word-count register bank: shared byte pointer, CPU read mux,
// channel select, transfer_address and sticky terminal-count status.
module kf8237_address_count_bank
    import KF8237_Common_Package::*;
#(
    parameter int CHANNELS    = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_clock_negedge,
    input  logic [7:0]            internal_data_bus,
    input  logic [CHANNELS-1:0]   write_address,
    input  logic [CHANNELS-1:0]   write_count,
    input  logic [CHANNELS-1:0]   read_address,
    input  logic [CHANNELS-1:0]   read_count,
    input  logic                  clear_byte_pointer,
    input  logic                  master_clear,
    output logic [7:0]            read_data,
    input  logic [CHANNELS-1:0]   transfer_select,
    input  logic                  initialize_current,
    input  logic                  address_hold,
    input  logic                  decrement_address,
    input  logic                  auto_initialize,
    input  logic                  next_word,
    input  logic                  clear_tc_status,
    output logic                  terminal_count,
    output logic                  update_high_address,
    output logic [ADDR_WIDTH-1:0] transfer_address,
    output logic [CHANNELS-1:0]   tc_status
);

    localparam int ADDR_BYTES  = bytes_of(ADDR_WIDTH);
    localparam int COUNT_BYTES = bytes_of(COUNT_WIDTH);
    localparam int MAX_BYTES   = (ADDR_BYTES > COUNT_BYTES) ? ADDR_BYTES : COUNT_BYTES;
    localparam int PTR_WIDTH   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int SEL_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PTR_WIDTH-1:0]   byte_pointer;
    logic [PTR_WIDTH-1:0]   pointer_next;
    int                     access_bytes;
    logic                   prev_read_address;
    logic                   prev_read_count;
    logic                   read_address_done;
    logic                   read_count_done;
    logic [SEL_WIDTH-1:0]   sel;
    logic [SEL_WIDTH-1:0]   read_sel;
    logic                   sel_valid;
    logic [ADDR_WIDTH-1:0]  current_address [CHANNELS];
    logic [COUNT_WIDTH-1:0] current_count [CHANNELS];
    logic [CHANNELS-1:0]    next_high_bit;
    logic [CHANNELS-1:0]    tc_set;
    logic [CHANNELS-1:0]    step;

    assign sel       = SEL_WIDTH'(onehot2num(8'(transfer_select)));
    assign sel_valid = |transfer_select;

    // A read access completes when its level strobe drops.
    assign read_address_done = prev_read_address & ~(|read_address);
    assign read_count_done   = prev_read_count & ~(|read_count);

    always_comb begin
        access_bytes = 0;
        if (|write_address) begin
            access_bytes = ADDR_BYTES;
        end else if (|write_count) begin
            access_bytes = COUNT_BYTES;
        end else if (read_address_done) begin
            access_bytes = ADDR_BYTES;
        end else if (read_count_done) begin
            access_bytes = COUNT_BYTES;
        end
        if (access_bytes == 0) begin
            pointer_next = byte_pointer;
        end else if (int'(byte_pointer) >= access_bytes - 1) begin
            pointer_next = '0;
        end else begin
            pointer_next = byte_pointer + PTR_WIDTH'(1);
        end
    end

    always_comb begin
        read_data = 8'h00;
        read_sel  = '0;
        if (|read_address) begin
            read_sel = SEL_WIDTH'(onehot2num(8'(read_address)));
            for (int i = 0; i < ADDR_BYTES; i++) begin
                if (int'(byte_pointer) == i) begin
                    read_data = current_address[read_sel][i*8 +: 8];
                end
            end
        end else if (|read_count) begin
            read_sel = SEL_WIDTH'(onehot2num(8'(read_count)));
            for (int i = 0; i < COUNT_BYTES; i++) begin
                if (int'(byte_pointer) == i) begin
                    read_data = current_count[read_sel][i*8 +: 8];
                end
            end
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
        assign step[ch] = sel_valid && (int'(sel) == ch) && next_word && cpu_clock_negedge;

        kf8237_channel_registers #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .COUNT_WIDTH (COUNT_WIDTH),
            .PTR_WIDTH   (PTR_WIDTH)
        ) u_channel (
            .clock              (clock),
            .reset_n            (reset_n),
            .master_clear       (master_clear),
            .internal_data_bus  (internal_data_bus),
            .byte_pointer       (byte_pointer),
            .write_address      (write_address[ch]),
            .write_count        (write_count[ch]),
            .initialize_current (initialize_current),
            .step               (step[ch]),
            .address_hold       (address_hold),
            .decrement_address  (decrement_address),
            .auto_initialize    (auto_initialize),
            .current_address    (current_address[ch]),
            .current_count      (current_count[ch]),
            .next_high_bit      (next_high_bit[ch]),
            .tc_set             (tc_set[ch])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_pointer      <= '0;
            prev_read_address <= 1'b0;
            prev_read_count   <= 1'b0;
            transfer_address  <= '0;
            tc_status         <= '0;
        end else begin
            prev_read_address <= |read_address;
            prev_read_count   <= |read_count;
            if (clear_byte_pointer || master_clear) begin
                byte_pointer <= '0;
            end else begin
                byte_pointer <= pointer_next;
            end
            if (master_clear) begin
                transfer_address <= '0;
            end else if (cpu_clock_negedge) begin
                transfer_address <= current_address[sel];
            end
            // A same-cycle terminal count outranks any clear.
            if (clear_tc_status || master_clear) begin
                tc_status <= tc_set;
            end else begin
                tc_status <= tc_status | tc_set;
            end
        end
    end

    assign terminal_count = (current_count[sel] == '0);

    if (ADDR_WIDTH > 8) begin : g_uha
        assign update_high_address = next_high_bit[sel] ^ transfer_address[8];
    end else begin : g_no_uha
        assign update_high_address = 1'b0;
    end

endmodule

// File: tb/tb_kf8237_address_count_bank.sv
// Bench for the address/count bank in a 4-channel, 24-bit address, 16-bit
// count configuration: directed scenarios plus randomized traffic vs a model.
module tb_kf8237_address_count_bank;

    localparam int CH = 4;
    localparam int AW = 24;
    localparam int CW = 16;
    localparam int AB = 3;
    localparam int CB = 2;
    localparam logic [31:0] AMASK = 32'h00FF_FFFF;
    localparam logic [31:0] CMASK = 32'h0000_FFFF;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          cpu_clock_negedge = 1'b0;
    logic [7:0]    internal_data_bus = 8'h00;
    logic [CH-1:0] write_address = '0;
    logic [CH-1:0] write_count = '0;
    logic [CH-1:0] read_address = '0;
    logic [CH-1:0] read_count = '0;
    logic          clear_byte_pointer = 1'b0;
    logic          master_clear = 1'b0;
    logic [7:0]    read_data;
    logic [CH-1:0] transfer_select = '0;
    logic          initialize_current = 1'b0;
    logic          address_hold = 1'b0;
    logic          decrement_address = 1'b0;
    logic          auto_initialize = 1'b0;
    logic          next_word = 1'b0;
    logic          clear_tc_status = 1'b0;
    logic          terminal_count;
    logic          update_high_address;
    logic [AW-1:0] transfer_address;
    logic [CH-1:0] tc_status;

    always #5 clock = ~clock;

    kf8237_address_count_bank #(
        .CHANNELS    (CH),
        .ADDR_WIDTH  (AW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .cpu_clock_negedge   (cpu_clock_negedge),
        .internal_data_bus   (internal_data_bus),
        .write_address       (write_address),
        .write_count         (write_count),
        .read_address        (read_address),
        .read_count          (read_count),
        .clear_byte_pointer  (clear_byte_pointer),
        .master_clear        (master_clear),
        .read_data           (read_data),
        .transfer_select     (transfer_select),
        .initialize_current  (initialize_current),
        .address_hold        (address_hold),
        .decrement_address   (decrement_address),
        .auto_initialize     (auto_initialize),
        .next_word           (next_word),
        .clear_tc_status     (clear_tc_status),
        .terminal_count      (terminal_count),
        .update_high_address (update_high_address),
        .transfer_address    (transfer_address),
        .tc_status           (tc_status)
    );

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Behavioural model: whole register values as plain integers.
    logic [31:0]   m_base_a [CH];
    logic [31:0]   m_cur_a [CH];
    logic [31:0]   m_base_c [CH];
    logic [31:0]   m_cur_c [CH];
    int            m_ptr;
    logic [31:0]   m_taddr;
    logic [CH-1:0] m_tc;
    bit            m_prev_ra;
    bit            m_prev_rc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int lowest(input logic [CH-1:0] v);
        for (int i = 0; i < CH; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input int idx, input logic [7:0] b);
        return (w & ~(32'hFF << (8 * idx))) | ({24'h0, b} << (8 * idx));
    endfunction

    function automatic logic [31:0] get_byte(input logic [31:0] w, input int idx);
        return (w >> (8 * idx)) & 32'hFF;
    endfunction

    function automatic logic [31:0] exp_read();
        if (read_address != 0) return (m_ptr < AB) ? get_byte(m_cur_a[lowest(read_address)], m_ptr) : 0;
        if (read_count != 0) return (m_ptr < CB) ? get_byte(m_cur_c[lowest(read_count)], m_ptr) : 0;
        return 0;
    endfunction

    function automatic logic [31:0] exp_uha();
        logic [31:0] cur;
        logic [31:0] nxt;
        cur = m_cur_a[lowest(transfer_select)];
        if (address_hold) nxt = cur;
        else if (decrement_address) nxt = (cur - 1) & AMASK;
        else nxt = (cur + 1) & AMASK;
        return {31'h0, nxt[8] != m_taddr[8]};
    endfunction

    task automatic model_step();
        int s;
        int bytes;
        int np;
        bit any;
        bit wa;
        bit wc;
        bit stp;
        logic [CH-1:0] set;
        s = lowest(transfer_select);
        any = (transfer_select != 0);
        set = '0;
        if (master_clear) m_taddr = 0;
        else if (cpu_clock_negedge) m_taddr = m_cur_a[s];
        bytes = 0;
        if (write_address != 0) bytes = AB;
        else if (write_count != 0) bytes = CB;
        else if (m_prev_ra && read_address == 0) bytes = AB;
        else if (m_prev_rc && read_count == 0) bytes = CB;
        np = m_ptr;
        if (clear_byte_pointer || master_clear) np = 0;
        else if (bytes != 0) np = (m_ptr + 1 >= bytes) ? 0 : m_ptr + 1;
        for (int ch = 0; ch < CH; ch++) begin
            wa = write_address[ch];
            wc = write_count[ch];
            stp = any && (s == ch) && next_word && cpu_clock_negedge;
            if (stp && !wa && !wc && !initialize_current && m_cur_c[ch] == 0) set[ch] = 1'b1;
            if (master_clear) begin
                m_base_a[ch] = 0; m_cur_a[ch] = 0; m_base_c[ch] = 0; m_cur_c[ch] = 0;
            end else if (wa || wc) begin
                if (wa && m_ptr < AB) begin
                    m_base_a[ch] = put_byte(m_base_a[ch], m_ptr, internal_data_bus);
                    m_cur_a[ch]  = put_byte(m_cur_a[ch], m_ptr, internal_data_bus);
                end
                if (wc && m_ptr < CB) begin
                    m_base_c[ch] = put_byte(m_base_c[ch], m_ptr, internal_data_bus);
                    m_cur_c[ch]  = put_byte(m_cur_c[ch], m_ptr, internal_data_bus);
                end
            end else if (initialize_current) begin
                m_cur_a[ch] = m_base_a[ch];
                m_cur_c[ch] = m_base_c[ch];
            end else if (stp) begin
                if (m_cur_c[ch] == 0 && auto_initialize) begin
                    m_cur_a[ch] = m_base_a[ch];
                    m_cur_c[ch] = m_base_c[ch];
                end else begin
                    if (!address_hold) m_cur_a[ch] = decrement_address ? (m_cur_a[ch] - 1) & AMASK
                                                                        : (m_cur_a[ch] + 1) & AMASK;
                    m_cur_c[ch] = (m_cur_c[ch] - 1) & CMASK;
                end
            end
        end
        m_tc = ((clear_tc_status || master_clear) ? '0 : m_tc) | set;
        m_ptr = np;
        m_prev_ra = (read_address != 0);
        m_prev_rc = (read_count != 0);
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < CH; ch++) begin
                m_base_a[ch] = 0; m_cur_a[ch] = 0; m_base_c[ch] = 0; m_cur_c[ch] = 0;
            end
            m_ptr = 0; m_taddr = 0; m_tc = '0; m_prev_ra = 1'b0; m_prev_rc = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            chk("read_data", {24'h0, read_data}, exp_read());
            chk("terminal_count", {31'h0, terminal_count}, {31'h0, m_cur_c[lowest(transfer_select)] == 0});
            chk("update_high_address", {31'h0, update_high_address}, exp_uha());
            chk("transfer_address", {8'h0, transfer_address}, m_taddr);
            chk("tc_status", {28'h0, tc_status}, {28'h0, m_tc});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        write_address = '0; write_count = '0; read_address = '0; read_count = '0;
        clear_byte_pointer = 1'b0; master_clear = 1'b0; initialize_current = 1'b0;
        next_word = 1'b0; clear_tc_status = 1'b0; internal_data_bus = 8'h00;
    endtask

    task automatic clear_ptr();
        clear_byte_pointer = 1'b1;
        tick();
        clear_byte_pointer = 1'b0;
    endtask

    task automatic write_reg(input int ch, input bit is_count, input logic [31:0] value, input int n);
        for (int k = 0; k < n; k++) begin
            internal_data_bus = 8'(get_byte(value, k));
            if (is_count) write_count = CH'(1 << ch);
            else write_address = CH'(1 << ch);
            tick();
            write_address = '0;
            write_count = '0;
        end
    endtask

    task automatic read_check(input int ch, input bit is_count, input logic [31:0] exp,
                              input int n, input string name);
        for (int k = 0; k < n; k++) begin
            if (is_count) read_count = CH'(1 << ch);
            else read_address = CH'(1 << ch);
            @(negedge clock);
            chk(name, {24'h0, read_data}, get_byte(exp, k));
            tick();
            read_address = '0;
            read_count = '0;
            tick();
        end
    endtask

    task automatic do_steps(input int n);
        next_word = 1'b1;
        cpu_clock_negedge = 1'b1;
        repeat (n) tick();
        next_word = 1'b0;
    endtask

    initial begin
        int r;
        idle();
        #1 reset_n = 1'b0;
        check_en = 1'b1;
        @(negedge clock);
        chk("reset read_data", {24'h0, read_data}, 32'h0);
        chk("reset terminal_count", {31'h0, terminal_count}, 32'h1);
        chk("reset transfer_address", {8'h0, transfer_address}, 32'h0);
        chk("reset tc_status", {28'h0, tc_status}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Multi-byte write and readback; the pointer wraps back to byte 0.
        write_reg(2, 1'b0, 32'h00AB_1234, 3);
        read_check(2, 1'b0, 32'h00AB_1234, 3, "ch2 address readback");
        read_check(2, 1'b0, 32'h0000_0034, 1, "pointer wrapped to byte 0");

        // Increment across the 0x100 boundary and through terminal count.
        clear_ptr();
        write_reg(1, 1'b0, 32'h0000_00FF, 3);
        write_reg(1, 1'b1, 32'h0000_0002, 2);
        transfer_select = 4'b0010;
        cpu_clock_negedge = 1'b1;
        tick();
        @(negedge clock);
        chk("update_high_address before step", {31'h0, update_high_address}, 32'h1);
        tick();
        do_steps(3);
        clear_ptr();
        read_check(1, 1'b0, 32'h0000_0102, 3, "ch1 address after steps");
        read_check(1, 1'b1, 32'h0000_FFFF, 2, "ch1 count wrapped");
        @(negedge clock);
        chk("tc_status ch1", {31'h0, tc_status[1]}, 32'h1);
        tick();

        // Auto-initialize reload on terminal count.
        clear_tc_status = 1'b1;
        tick();
        clear_tc_status = 1'b0;
        clear_ptr();
        write_reg(0, 1'b0, 32'h0000_1000, 3);
        write_reg(0, 1'b1, 32'h0000_0001, 2);
        transfer_select = 4'b0001;
        auto_initialize = 1'b1;
        do_steps(2);
        auto_initialize = 1'b0;
        clear_ptr();
        read_check(0, 1'b0, 32'h0000_1000, 3, "ch0 address reloaded");
        read_check(0, 1'b1, 32'h0000_0001, 2, "ch0 count reloaded");
        @(negedge clock);
        chk("tc_status after reload", {28'h0, tc_status}, 32'h1);
        tick();

        // Decrement wraps below zero; hold freezes the address only.
        clear_ptr();
        write_reg(3, 1'b0, 32'h0, 3);
        write_reg(3, 1'b1, 32'h0000_0005, 2);
        transfer_select = 4'b1000;
        decrement_address = 1'b1;
        do_steps(1);
        read_check(3, 1'b0, 32'h00FF_FFFF, 3, "ch3 decrement wrap");
        address_hold = 1'b1;
        do_steps(2);
        address_hold = 1'b0;
        decrement_address = 1'b0;
        read_check(3, 1'b0, 32'h00FF_FFFF, 3, "ch3 address held");
        read_check(3, 1'b1, 32'h0000_0002, 2, "ch3 count with hold");

        // Write beats a same-cycle step; clear_byte_pointer lets the write use the old pointer.
        clear_ptr();
        transfer_select = 4'b0100;
        next_word = 1'b1;
        write_address = 4'b0100;
        internal_data_bus = 8'h5A;
        tick();
        next_word = 1'b0;
        internal_data_bus = 8'h66;
        clear_byte_pointer = 1'b1;
        tick();
        idle();
        read_check(2, 1'b0, 32'h00AB_665A, 3, "write over step");
        @(negedge clock);
        chk("no tc from lost step", {31'h0, tc_status[2]}, 32'h0);
        tick();

        // Reset in the middle of a multi-byte write.
        clear_ptr();
        write_reg(0, 1'b0, 32'h0000_0055, 1);
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid reset terminal_count", {31'h0, terminal_count}, 32'h1);
        chk("mid reset tc_status", {28'h0, tc_status}, 32'h0);
        tick();
        reset_n = 1'b1;
        transfer_select = '0;
        cpu_clock_negedge = 1'b0;
        tick();
        write_reg(0, 1'b0, 32'h0000_0077, 1);
        clear_ptr();
        read_check(0, 1'b0, 32'h0000_0077, 3, "write after reset lands in byte 0");
        read_check(2, 1'b0, 32'h0, 3, "ch2 cleared by reset");

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            write_address = '0;
            write_count = '0;
            r = $urandom_range(0, 11);
            if (r == 0) write_address = CH'(1 << $urandom_range(0, CH - 1));
            else if (r == 1) write_count = CH'(1 << $urandom_range(0, CH - 1));
            r = $urandom_range(0, 9);
            if (r < 2) begin
                read_address = '0;
                read_count = '0;
                if ($urandom_range(0, 1) == 1) read_address = CH'(1 << $urandom_range(0, CH - 1));
                else read_count = CH'(1 << $urandom_range(0, CH - 1));
            end else if (r > 5) begin
                read_address = '0;
                read_count = '0;
            end
            internal_data_bus = 8'($urandom);
            clear_byte_pointer = ($urandom_range(0, 19) == 0);
            master_clear = ($urandom_range(0, 99) == 0);
            clear_tc_status = ($urandom_range(0, 19) == 0);
            initialize_current = ($urandom_range(0, 29) == 0);
            transfer_select = CH'($urandom);
            next_word = ($urandom_range(0, 1) == 1);
            cpu_clock_negedge = ($urandom_range(0, 1) == 1);
            address_hold = ($urandom_range(0, 3) == 0);
            decrement_address = ($urandom_range(0, 1) == 1);
            auto_initialize = ($urandom_range(0, 1) == 1);
            reset_n = ($urandom_range(0, 399) != 0);
            tick();
        end

        idle();
        reset_n = 1'b1;
        tick();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
